irq_vector_arbiter: RTL

Central interrupt scheduler between all peripheral IRQ sources (EXTINT, PCINT, timers, USART, ...) and the AVR core. It performs fixed-priority arbitration, where the lowest vector number wins. It presents one latched vector to the core and runs the taken/acknowledge handshake. On acknowledge it returns irqack/irqack_addr to the peripherals so the owning flag auto-clears. It also enforces the AVR rule that one instruction executes after RETI before the next interrupt is taken.

---
 rtl/irq_vector_arbiter_if.sv | 43 ++++
 rtl/irq_vector_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/irq_vector_arbiter_if.sv
// -----------------------------------------------------------------------------
// irq_vector_arbiter_if
// Bundles the interrupt request/acknowledge signals exchanged between the
// peripherals, the AVR core and the vector arbiter.
//   irq_lines      : level requests, bit k-1 belongs to vector k
//   global_int_en  : SREG I flag
//   instr_boundary : core instruction boundary pulse
//   irq_taken      : core accepts the presented vector
//   reti_done      : core finished RETI
//   irq_req        : request to the core
//   irq_vector     : vector presented to the core
//   irqack         : acknowledge strobe to the peripherals
//   irqack_addr    : vector being acknowledged
//   wake_req       : any request pending, for sleep wake-up
//   arb_state      : arbiter state, debug visibility
// Modports: master = core/peripheral side, slave = arbiter.
// -----------------------------------------------------------------------------
interface irq_vector_arbiter_if #(
    parameter int NUM_VEC = 45,
    parameter int VEC_W   = 6
);
    logic [NUM_VEC-2:0] irq_lines;
    logic               global_int_en;
    logic               instr_boundary;
    logic               irq_taken;
    logic               reti_done;
    logic               irq_req;
    logic [VEC_W-1:0]   irq_vector;
    logic               irqack;
    logic [VEC_W-1:0]   irqack_addr;
    logic               wake_req;
    logic [2:0]         arb_state;

    modport master (
        output irq_lines, global_int_en, instr_boundary, irq_taken, reti_done,
        input  irq_req, irq_vector, irqack, irqack_addr, wake_req, arb_state
    );

    modport slave (
        input  irq_lines, global_int_en, instr_boundary, irq_taken, reti_done,
        output irq_req, irq_vector, irqack, irqack_addr, wake_req, arb_state
    );
endinterface

// File: rtl/irq_vector_arbiter.sv
// -----------------------------------------------------------------------------
// irq_vector_arbiter
// Fixed-priority interrupt scheduler for the AVR core: the lowest pending
// vector wins, is latched and presented to the core, and on acceptance an
// acknowledge strobe with the vector number is returned to the peripherals.
// After RETI one instruction must complete before the next interrupt.
// Ports:
//   cp2    : system clock, rising edge
//   ireset : asynchronous active-low reset
//   bus    : irq_vector_arbiter_if slave modport (see interface header)
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no vector presented; waiting for a request or RETI
//   REQ     | irq_req high, vector frozen until taken or cancelled
//   ACK     | one-cycle irqack strobe with the taken vector
//   HOLDOFF | after RETI, wait for one instruction boundary
// -----------------------------------------------------------------------------
module irq_vector_arbiter #(
    parameter int NUM_VEC = 45,
    parameter int VEC_W   = 6
) (
    input logic                 cp2,
    input logic                 ireset,
    irq_vector_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ACK     = 3'd2,
        HOLDOFF = 3'd3
    } state_t;

    localparam int LW = 2 ** VEC_W;

    state_t           state;
    logic             irq_req_q;
    logic [VEC_W-1:0] irq_vector_q;
    logic             irqack_q;
    logic [VEC_W-1:0] irqack_addr_q;

    logic             any;
    logic [VEC_W-1:0] enc;
    logic [LW-1:0]    lines_ext;

    // Lines re-indexed by vector number (bit 0 = reset vector, never set) so
    // the latched vector can look up its own request line directly.
    assign lines_ext = LW'({bus.irq_lines, 1'b0});
    assign any       = |bus.irq_lines;

    always_comb begin
        enc = '0;
        for (int k = NUM_VEC - 1; k >= 1; k--) begin
            if (bus.irq_lines[k-1]) enc = VEC_W'(k);
        end
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state         <= IDLE;
            irq_req_q     <= 1'b0;
            irq_vector_q  <= '0;
            irqack_q      <= 1'b0;
            irqack_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.reti_done) begin
                        state <= HOLDOFF;
                    end else if (any && bus.global_int_en) begin
                        state        <= REQ;
                        irq_req_q    <= 1'b1;
                        irq_vector_q <= enc;
                    end
                end
                REQ: begin
                    // Taken wins over a same-cycle cancellation.
                    if (bus.irq_taken) begin
                        state         <= ACK;
                        irq_req_q     <= 1'b0;
                        irqack_q      <= 1'b1;
                        irqack_addr_q <= irq_vector_q;
                    end else if (!bus.global_int_en || !lines_ext[irq_vector_q]) begin
                        state     <= IDLE;
                        irq_req_q <= 1'b0;
                    end
                end
                ACK: begin
                    irqack_q <= 1'b0;
                    state    <= bus.reti_done ? HOLDOFF : IDLE;
                end
                HOLDOFF: begin
                    if (bus.instr_boundary) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    irq_req_q <= 1'b0;
                    irqack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_req     = irq_req_q;
    assign bus.irq_vector  = irq_vector_q;
    assign bus.irqack      = irqack_q;
    assign bus.irqack_addr = irqack_addr_q;
    assign bus.wake_req    = any;
    assign bus.arb_state   = state;

endmodule
